// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
// CLK-synchronous SPI slave. SCLK, MOSI and SS are oversampled through
// synchronisers, so CLK must run at >= 8x SCLK. All four CPOL/CPHA modes are
// supported, along with MSB- or LSB-first shifting and multi-word frames under
// one SS. On-chip logic supplies MISO words and consumes MOSI words through
// valid/ready streams.
//
// Ports
//   CLK, RST           system clock, asynchronous active-high reset
//   SCLK, MOSI, SS     SPI pins from the master (SS active-low)
//   MISO               slave data out, high impedance outside a frame
//   tx_data/valid      word offered for transmission; tx_ready = holding reg empty
//   rx_data/valid      last complete received word; held until rx_ready
//   frame_active       synchronised SS is low and the frame was entered
//   rx_overrun         pulse: a word completed while rx_valid was still pending
//   tx_underrun        pulse: TX_IDLE_WORD was loaded for lack of a tx word
//   frame_error        pulse: SS rose with a partial word in flight
// -----------------------------------------------------------------------------
module spi_slave_core #(
   parameter int                     DATA_LENGTH  = 8,
   parameter bit                     CPOL         = 1'b0,
   parameter bit                     CPHA         = 1'b0,
   parameter bit                     LSB_FIRST    = 1'b0,
   parameter int                     SYNC_STAGES  = 2,
   parameter logic [DATA_LENGTH-1:0] TX_IDLE_WORD = DATA_LENGTH'(8'hFF)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   SCLK,
   input  logic                   MOSI,
   input  logic                   SS,
   output logic                   MISO,
   input  logic [DATA_LENGTH-1:0] tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic [DATA_LENGTH-1:0] rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic                   frame_active,
   output logic                   rx_overrun,
   output logic                   tx_underrun,
   output logic                   frame_error
);

   localparam int            CW       = $clog2(DATA_LENGTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_LENGTH - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam int            MISO_BIT = LSB_FIRST ? 0 : DATA_LENGTH - 1;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_r, mosi_sync_r, ss_sync_r;
   logic                   sclk_prev_r, primed_r, armed_r;
   state_t                 state_r, state_next_s;
   logic                   frame_active_r;
   logic [DATA_LENGTH-1:0] rx_shift_r, rx_data_r, hold_r, tx_shift_r;
   logic [CW-1:0]          rx_cnt_r, tx_cnt_r;
   logic                   word_done_r, rx_valid_r, rx_overrun_r, frame_error_r;
   logic                   pending_r, tx_underrun_r;

   logic                   sclk_s, mosi_s, ss_s, lead_s, trail_s;
   logic                   enter_s, leave_s, in_frame_s, sample_s, shift_s;
   logic                   load_s, accept_s;
   logic [DATA_LENGTH-1:0] rx_next_s, tx_shifted_s;
   logic [CW-1:0]          rx_cnt_next_s, tx_cnt_next_s;

   // Pin synchronisers, SCLK edge history and post-reset arming of SS
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sclk_sync_r <= {SYNC_STAGES{CPOL}};
         mosi_sync_r <= '0;
         ss_sync_r   <= '1;
         sclk_prev_r <= CPOL;
         primed_r    <= 1'b0;
         armed_r     <= 1'b0;
      end else begin
         sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
         ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], SS};
         sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
         // The preset SS=1 is not a real observation. Frames are only
         // accepted once a genuine high level on SS has been sampled, so a
         // master still holding SS low through a reset cannot re-enter mid-frame.
         primed_r    <= 1'b1;
         armed_r     <= armed_r | (primed_r & ss_sync_r[0]);
      end
   end

   // Edge detection, frame control, rx/tx next-state decode
   always_comb begin
      sclk_s     = sclk_sync_r[SYNC_STAGES-1];
      mosi_s     = mosi_sync_r[SYNC_STAGES-1];
      ss_s       = ss_sync_r[SYNC_STAGES-1];
      lead_s     = (sclk_prev_r == CPOL) && (sclk_s != CPOL);
      trail_s    = (sclk_prev_r != CPOL) && (sclk_s == CPOL);
      enter_s    = (state_r == ST_IDLE) && !ss_s && armed_r;
      leave_s    = (state_r == ST_ACTIVE) && ss_s;
      in_frame_s = (state_r == ST_ACTIVE) && !ss_s;
      accept_s   = tx_valid && !pending_r;

      state_next_s = state_r;
      case (state_r)
         ST_IDLE:   if (enter_s) state_next_s = ST_ACTIVE; else state_next_s = ST_IDLE;
         ST_ACTIVE: if (ss_s)    state_next_s = ST_IDLE;   else state_next_s = ST_ACTIVE;
         default:   state_next_s = ST_IDLE;
      endcase

      if (CPHA) begin
         sample_s = in_frame_s && trail_s;
         shift_s  = in_frame_s && lead_s;
         load_s   = shift_s && (tx_cnt_r == CNT_ZERO);
      end else begin
         sample_s = in_frame_s && lead_s;
         shift_s  = in_frame_s && trail_s;
         // The first word is preloaded at frame entry so MISO is valid
         // before the first sampling edge.
         load_s   = enter_s || (shift_s && (tx_cnt_r == LAST_BIT));
      end

      if (LSB_FIRST) begin
         rx_next_s    = {mosi_s, rx_shift_r[DATA_LENGTH-1:1]};
         tx_shifted_s = {1'b0, tx_shift_r[DATA_LENGTH-1:1]};
      end else begin
         rx_next_s    = {rx_shift_r[DATA_LENGTH-2:0], mosi_s};
         tx_shifted_s = {tx_shift_r[DATA_LENGTH-2:0], 1'b0};
      end

      if (leave_s) begin
         rx_cnt_next_s = CNT_ZERO;
      end else if (sample_s) begin
         rx_cnt_next_s = (rx_cnt_r == LAST_BIT) ? CNT_ZERO : rx_cnt_r + CNT_ONE;
      end else begin
         rx_cnt_next_s = rx_cnt_r;
      end

      if (enter_s || leave_s) begin
         tx_cnt_next_s = CNT_ZERO;
      end else if (shift_s) begin
         tx_cnt_next_s = (tx_cnt_r == LAST_BIT) ? CNT_ZERO : tx_cnt_r + CNT_ONE;
      end else begin
         tx_cnt_next_s = tx_cnt_r;
      end
   end

   // Frame state register and registered frame_active
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r        <= ST_IDLE;
         frame_active_r <= 1'b0;
      end else begin
         state_r        <= state_next_s;
         frame_active_r <= (state_next_s == ST_ACTIVE);
      end
   end

   // Receive shifter, bit counter, word-complete and frame-error pulses
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_shift_r    <= '0;
         rx_cnt_r      <= CNT_ZERO;
         word_done_r   <= 1'b0;
         frame_error_r <= 1'b0;
      end else begin
         rx_cnt_r      <= rx_cnt_next_s;
         frame_error_r <= leave_s && (rx_cnt_r != CNT_ZERO);
         word_done_r   <= sample_s && (rx_cnt_r == LAST_BIT);
         if (sample_s) begin
            rx_shift_r <= rx_next_s;
         end
      end
   end

   // Receive output register with valid/ready handshake and overrun pulse
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_data_r    <= '0;
         rx_valid_r   <= 1'b0;
         rx_overrun_r <= 1'b0;
      end else if (word_done_r) begin
         // A landing word wins over a same-cycle acceptance: valid stays set.
         rx_data_r    <= rx_shift_r;
         rx_valid_r   <= 1'b1;
         rx_overrun_r <= rx_valid_r && !rx_ready;
      end else begin
         rx_overrun_r <= 1'b0;
         if (rx_valid_r && rx_ready) begin
            rx_valid_r <= 1'b0;
         end
      end
   end

   // Transmit holding register, shift register, bit counter and underrun pulse
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hold_r        <= '0;
         pending_r     <= 1'b0;
         tx_shift_r    <= '0;
         tx_cnt_r      <= CNT_ZERO;
         tx_underrun_r <= 1'b0;
      end else begin
         // accept_s implies nothing was pending, so a same-cycle load takes
         // the idle word and the freshly accepted word stays pending.
         if (accept_s) begin
            hold_r    <= tx_data;
            pending_r <= 1'b1;
         end else if (load_s) begin
            pending_r <= 1'b0;
         end
         if (load_s) begin
            tx_shift_r    <= pending_r ? hold_r : TX_IDLE_WORD;
            tx_underrun_r <= !pending_r;
         end else if (shift_s) begin
            tx_shift_r    <= tx_shifted_s;
            tx_underrun_r <= 1'b0;
         end else begin
            tx_underrun_r <= 1'b0;
         end
         tx_cnt_r <= tx_cnt_next_s;
      end
   end

   assign MISO         = frame_active_r ? tx_shift_r[MISO_BIT] : 1'bz;
   assign tx_ready     = ~pending_r;
   assign rx_data      = rx_data_r;
   assign rx_valid     = rx_valid_r;
   assign frame_active = frame_active_r;
   assign rx_overrun   = rx_overrun_r;
   assign tx_underrun  = tx_underrun_r;
   assign frame_error  = frame_error_r;

endmodule

// File: tb/tb_spi_slave_core.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_core
// Directed bench for spi_slave_core. Five instances share CLK/RST:
//   0: mode 0, MSB first      1..4: modes 0..3, LSB first
// A behavioural SPI master drives each instance's own pins; expected words
// are written out by hand in the stimulus.
// -----------------------------------------------------------------------------
module tb_spi_slave_core;

   localparam int HALF = 8;   // CLK cycles per SCLK half period

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [4:0]      sclk_v     = 5'b11000;   // instances 3,4 idle high (CPOL=1)
   logic [4:0]      ss_v       = 5'b11111;
   logic [4:0]      mosi_v     = 5'b00000;
   logic [4:0]      tx_valid_v = 5'b00000;
   logic [4:0]      rx_ready_v = 5'b00000;
   logic [4:0][7:0] tx_data_v  = '0;
   wire  [4:0]      miso_v, tx_ready_v, rx_valid_v, frame_active_v;
   wire  [4:0]      rx_overrun_v, tx_underrun_v, frame_error_v;
   wire  [4:0][7:0] rx_data_v;

   int n_checks = 0;
   int n_pass   = 0;

   int         und2_cnt  = 0;
   int         ovr0_cnt  = 0;
   int         ferr0_cnt = 0;
   int         rx2_cnt   = 0;
   logic [7:0] rx2_log [16];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 5; k++) begin : g_dut
      localparam bit P_CPOL = (k >= 3);
      localparam bit P_CPHA = (k == 2) || (k == 4);
      localparam bit P_LSB  = (k != 0);
      wire miso_w;
      spi_slave_core #(
         .DATA_LENGTH (8),
         .CPOL        (P_CPOL),
         .CPHA        (P_CPHA),
         .LSB_FIRST   (P_LSB),
         .SYNC_STAGES (2),
         .TX_IDLE_WORD(8'hFF)
      ) u_dut (
         .CLK         (clk),
         .RST         (rst),
         .SCLK        (sclk_v[k]),
         .MOSI        (mosi_v[k]),
         .SS          (ss_v[k]),
         .MISO        (miso_w),
         .tx_data     (tx_data_v[k]),
         .tx_valid    (tx_valid_v[k]),
         .tx_ready    (tx_ready_v[k]),
         .rx_data     (rx_data_v[k]),
         .rx_valid    (rx_valid_v[k]),
         .rx_ready    (rx_ready_v[k]),
         .frame_active(frame_active_v[k]),
         .rx_overrun  (rx_overrun_v[k]),
         .tx_underrun (tx_underrun_v[k]),
         .frame_error (frame_error_v[k])
      );
      assign miso_v[k] = miso_w;
   end

   // Pulse counters and accepted-word log, sampled on the inactive edge
   always @(negedge clk) begin
      if (tx_underrun_v[2]) und2_cnt  <= und2_cnt + 1;
      if (rx_overrun_v[0])  ovr0_cnt  <= ovr0_cnt + 1;
      if (frame_error_v[0]) ferr0_cnt <= ferr0_cnt + 1;
      if (rx_valid_v[2] && rx_ready_v[2] && (rx2_cnt < 16)) begin
         rx2_log[rx2_cnt] <= rx_data_v[2];
         rx2_cnt          <= rx2_cnt + 1;
      end
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_push(input int k, input logic [7:0] d);
      tx_data_v[k]  = d;
      tx_valid_v[k] = 1'b1;
      @(negedge clk);
      tx_valid_v[k] = 1'b0;
   endtask

   task automatic rx_accept(input int k);
      rx_ready_v[k] = 1'b1;
      @(negedge clk);
      rx_ready_v[k] = 1'b0;
   endtask

   task automatic ss_low(input int k);
      ss_v[k] = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic ss_high(input int k);
      wait_clk(HALF);
      ss_v[k] = 1'b1;
      wait_clk(HALF);
   endtask

   // Master shifting nbits of mo; returns the bits it sampled from MISO.
   task automatic xfer_bits(input int k, input logic [7:0] mo, input int nbits,
                            input bit chk_lat, output logic [7:0] mi);
      bit pol, pha, lsb;
      int idx;
      pol = (k >= 3);
      pha = (k == 2) || (k == 4);
      lsb = (k != 0);
      mi  = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         idx = lsb ? i : 7 - i;
         if (!pha) begin
            mosi_v[k] = mo[idx];
            wait_clk(HALF);
            sclk_v[k] = ~pol;                 // leading edge: both sides sample
            mi[idx]   = miso_v[k];
            for (int j = 1; j <= HALF; j++) begin
               @(negedge clk);
               if (chk_lat && (i == nbits - 1) && (j == 3))
                  check_value("lat_before", rx_valid_v[k], 1'b0);
               if (chk_lat && (i == nbits - 1) && (j == 4))
                  check_value("lat_at", rx_valid_v[k], 1'b1);
            end
            sclk_v[k] = pol;
         end else begin
            sclk_v[k] = ~pol;                 // leading edge: both sides shift
            mosi_v[k] = mo[idx];
            wait_clk(HALF);
            sclk_v[k] = pol;                  // trailing edge: both sides sample
            mi[idx]   = miso_v[k];
            wait_clk(HALF);
         end
      end
   endtask

   initial begin
      logic [7:0] mi;
      logic [7:0] d;
      int u0, o0, f0, r0;

      // ---------------- reset state
      @(negedge clk);
      rst = 1'b1;
      wait_clk(2);
      for (int k = 0; k < 5; k++) begin
         check_value($sformatf("rst_tx_ready%0d", k),     tx_ready_v[k],     1'b1);
         check_value($sformatf("rst_rx_valid%0d", k),     rx_valid_v[k],     1'b0);
         check_value($sformatf("rst_frame_active%0d", k), frame_active_v[k], 1'b0);
         check_value($sformatf("rst_rx_data%0d", k),      rx_data_v[k],      8'h00);
      end
      check_value("rst_pulses", {rx_overrun_v[0], tx_underrun_v[0], frame_error_v[0]}, 3'b000);
      rst = 1'b0;
      wait_clk(6);

      // ---------------- 1: mode 0 MSB first, tx A5, master sends 3C
      tx_push(0, 8'hA5);
      check_value("t1_tx_ready_low", tx_ready_v[0], 1'b0);
      ss_low(0);
      check_value("t1_frame_active", frame_active_v[0], 1'b1);
      xfer_bits(0, 8'h3C, 8, 1'b1, mi);
      check_value("t1_miso", mi, 8'hA5);
      ss_high(0);
      check_value("t1_frame_idle", frame_active_v[0], 1'b0);
      check_value("t1_rx_data", rx_data_v[0], 8'h3C);
      wait_clk(20);
      check_value("t1_rx_valid_held", rx_valid_v[0], 1'b1);
      rx_accept(0);
      check_value("t1_rx_valid_clr", rx_valid_v[0], 1'b0);

      // ---------------- 2: four modes, LSB first, master sends 01
      for (int k = 1; k < 5; k++) begin
         d = 8'h30 + 8'(k);
         tx_push(k, d);
         ss_low(k);
         xfer_bits(k, 8'h01, 8, 1'b0, mi);
         ss_high(k);
         check_value($sformatf("t2_miso_m%0d", k - 1),     mi,            d);
         check_value($sformatf("t2_rx_data_m%0d", k - 1),  rx_data_v[k],  8'h01);
         check_value($sformatf("t2_rx_valid_m%0d", k - 1), rx_valid_v[k], 1'b1);
         rx_accept(k);
      end

      // ---------------- 3: mode 1, three words under one SS, only C0 queued
      u0 = und2_cnt;
      r0 = rx2_cnt;
      rx_ready_v[2] = 1'b1;
      tx_push(2, 8'hC0);
      ss_low(2);
      xfer_bits(2, 8'h11, 8, 1'b0, mi);
      check_value("t3_miso_w0", mi, 8'hC0);
      xfer_bits(2, 8'h22, 8, 1'b0, mi);
      check_value("t3_miso_w1", mi, 8'hFF);
      xfer_bits(2, 8'h33, 8, 1'b0, mi);
      check_value("t3_miso_w2", mi, 8'hFF);
      ss_high(2);
      wait_clk(10);
      rx_ready_v[2] = 1'b0;
      check_value("t3_underruns", und2_cnt - u0, 2);
      check_value("t3_rx_count",  rx2_cnt - r0,  3);
      check_value("t3_rx_w0", rx2_log[r0],     8'h11);
      check_value("t3_rx_w1", rx2_log[r0 + 1], 8'h22);
      check_value("t3_rx_w2", rx2_log[r0 + 2], 8'h33);

      // ---------------- 4: rx_ready low across 55, AA
      o0 = ovr0_cnt;
      ss_low(0);
      xfer_bits(0, 8'h55, 8, 1'b0, mi);
      xfer_bits(0, 8'hAA, 8, 1'b0, mi);
      ss_high(0);
      wait_clk(10);
      check_value("t4_overruns", ovr0_cnt - o0, 1);
      check_value("t4_rx_data",  rx_data_v[0],  8'hAA);
      check_value("t4_rx_valid", rx_valid_v[0], 1'b1);
      rx_accept(0);
      check_value("t4_rx_valid_clr", rx_valid_v[0], 1'b0);

      // ---------------- 5: SS raised after 5 bits, then a full 7E frame
      f0 = ferr0_cnt;
      ss_low(0);
      xfer_bits(0, 8'hE7, 5, 1'b0, mi);
      ss_high(0);
      wait_clk(10);
      check_value("t5_frame_error", ferr0_cnt - f0, 1);
      check_value("t5_no_rx_valid", rx_valid_v[0], 1'b0);
      ss_low(0);
      xfer_bits(0, 8'h7E, 8, 1'b0, mi);
      ss_high(0);
      wait_clk(10);
      check_value("t5_rx_data",  rx_data_v[0],   8'h7E);
      check_value("t5_rx_valid", rx_valid_v[0],  1'b1);
      check_value("t5_clean_end", ferr0_cnt - f0, 1);
      rx_accept(0);

      // ---------------- 6: RST pulse at bit 4 with a word pending
      f0 = ferr0_cnt;
      tx_push(0, 8'h3C);
      ss_low(0);
      tx_push(0, 8'h42);
      xfer_bits(0, 8'hF0, 4, 1'b0, mi);
      check_value("t6_tx_ready_pre", tx_ready_v[0], 1'b0);
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      @(negedge clk);
      check_value("t6_frame_active", frame_active_v[0], 1'b0);
      check_value("t6_rx_valid",     rx_valid_v[0],     1'b0);
      check_value("t6_tx_ready",     tx_ready_v[0],     1'b1);
      check_value("t6_rx_data",      rx_data_v[0],      8'h00);
      wait_clk(20);
      check_value("t6_no_rejoin", frame_active_v[0], 1'b0);
      check_value("t6_no_error",  ferr0_cnt - f0,    0);
      ss_v[0] = 1'b1;
      wait_clk(HALF);
      ss_low(0);
      xfer_bits(0, 8'h96, 8, 1'b0, mi);
      ss_high(0);
      wait_clk(10);
      check_value("t6_miso_idle", mi,            8'hFF);
      check_value("t6_rx_data2",  rx_data_v[0],  8'h96);
      check_value("t6_rx_valid2", rx_valid_v[0], 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
